// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seg7_pkg
// Purpose  : Segment bit order, glyph constants and hex-to-segment helper.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Segment vector order is {g,f,e,d,c,b,a}; a 1 means the segment is lit.
    localparam int SEG_BIT_A = 0;
    localparam int SEG_BIT_B = 1;
    localparam int SEG_BIT_C = 2;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 4;
    localparam int SEG_BIT_F = 5;
    localparam int SEG_BIT_G = 6;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t SEG_0     = 7'b0111111;
    localparam seg_t SEG_1     = 7'b0000110;
    localparam seg_t SEG_2     = 7'b1011011;
    localparam seg_t SEG_3     = 7'b1001111;
    localparam seg_t SEG_4     = 7'b1100110;
    localparam seg_t SEG_5     = 7'b1101101;
    localparam seg_t SEG_6     = 7'b1111101;
    localparam seg_t SEG_7     = 7'b0000111;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1101111;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b1111100;
    localparam seg_t SEG_C     = 7'b0111001;
    localparam seg_t SEG_D     = 7'b1011110;
    localparam seg_t SEG_E     = 7'b1111001;
    localparam seg_t SEG_F     = 7'b1110001;

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_hex_decoder
// Purpose  : Combinational nibble (hex mode) or single bit (binary mode) to
//            active-high segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_mode,
    output seg_t       o_seg
);

    // Binary mode looks only at bit 0 of the nibble.
    always_comb begin
        o_seg = SEG_BLANK;
        if (i_mode) begin
            o_seg = hex_to_seg(i_nibble);
        end else begin
            o_seg = i_nibble[0] ? SEG_1 : SEG_0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_controller
// Purpose  : Multiplexed seven-segment scanner; loaded data is committed only
//            at frame boundaries so a frame never mixes old and new data.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 262144,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                    clock_10Mhz,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    data_load,
    input  logic                    mode,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   anode_activate,
    output logic [6:0]              led_out,
    output logic                    frame_done,
    output logic                    load_pending
);

    localparam int c_DATA_W  = 4 * NUM_DIGITS;
    localparam int c_PRESC_W = $clog2(REFRESH_DIV);
    localparam int c_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX  = c_IDX_W'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] c_ANODE_OFF = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam seg_t                  c_SEG_OFF   = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [c_PRESC_W-1:0]  r_prescaler;
    logic [c_IDX_W-1:0]    r_digit_idx;
    logic [c_DATA_W-1:0]   r_pending;
    logic                  r_pending_mode;
    logic [c_DATA_W-1:0]   r_display;
    logic                  r_disp_mode;
    logic                  r_load_pending;
    logic                  r_frame_done;
    logic [NUM_DIGITS-1:0] r_anode;
    seg_t                  r_led;

    logic                  w_presc_tc;
    logic                  w_frame_end;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [NUM_DIGITS-1:0] w_lz;
    logic [3:0]            w_sel_nibble;
    logic                  w_sel_bit;
    logic                  w_sel_en;
    logic                  w_sel_lz;
    logic                  w_blank;
    logic [3:0]            w_dec_nibble;
    seg_t                  w_dec_seg;
    seg_t                  w_seg_lit;

    assign w_presc_tc  = (r_prescaler == c_PRESC_MAX);
    assign w_frame_end = w_presc_tc && (r_digit_idx == c_LAST_IDX);

    always_ff @(posedge clock_10Mhz or negedge reset) begin
        if (!reset) begin
            r_prescaler <= '0;
            r_digit_idx <= '0;
        end else if (w_presc_tc) begin
            r_prescaler <= '0;
            r_digit_idx <= (r_digit_idx == c_LAST_IDX) ? '0 : r_digit_idx + c_IDX_W'(1);
        end else begin
            r_prescaler <= r_prescaler + c_PRESC_W'(1);
        end
    end

    // A load landing exactly on the boundary bypasses pending and is shown next frame.
    always_ff @(posedge clock_10Mhz or negedge reset) begin
        if (!reset) begin
            r_pending      <= '0;
            r_pending_mode <= 1'b0;
            r_display      <= '0;
            r_disp_mode    <= 1'b0;
            r_load_pending <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (data_load) begin
                if (w_frame_end) begin
                    r_display      <= data_in;
                    r_disp_mode    <= mode;
                    r_load_pending <= 1'b0;
                end else begin
                    r_pending      <= data_in;
                    r_pending_mode <= mode;
                    r_load_pending <= 1'b1;
                end
            end else if (w_frame_end && r_load_pending) begin
                r_display      <= r_pending;
                r_disp_mode    <= r_pending_mode;
                r_load_pending <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_onehot[gi] = (r_digit_idx == c_IDX_W'(gi));
        if (gi == 0) begin : g_rightmost
            assign w_lz[gi] = 1'b0;
        end else begin : g_upper
            // Blankable only when this nibble and every more-significant one is zero.
            assign w_lz[gi] = ~|r_display[c_DATA_W-1:4*gi];
        end
    end

    always_comb begin
        w_sel_nibble = '0;
        w_sel_bit    = 1'b0;
        w_sel_en     = 1'b0;
        w_sel_lz     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_onehot[i]) begin
                w_sel_nibble = r_display[4*i +: 4];
                w_sel_bit    = r_display[i];
                w_sel_en     = digit_en[i];
                w_sel_lz     = w_lz[i];
            end
        end
    end

    assign w_blank      = r_disp_mode && blank_lz && w_sel_lz;
    assign w_dec_nibble = r_disp_mode ? w_sel_nibble : {3'b000, w_sel_bit};

    seg7_hex_decoder u_decoder (
        .i_nibble (w_dec_nibble),
        .i_mode   (r_disp_mode),
        .o_seg    (w_dec_seg)
    );

    assign w_seg_lit = (w_sel_en && !w_blank) ? w_dec_seg : SEG_BLANK;

    always_ff @(posedge clock_10Mhz or negedge reset) begin
        if (!reset) begin
            r_anode <= c_ANODE_OFF;
            r_led   <= c_SEG_OFF;
        end else begin
            r_anode <= (w_onehot & digit_en) ^ c_ANODE_OFF;
            r_led   <= w_seg_lit ^ c_SEG_OFF;
        end
    end

    assign anode_activate = r_anode;
    assign led_out        = r_led;
    assign frame_done     = r_frame_done;
    assign load_pending   = r_load_pending;

endmodule
`default_nettype wire
